mem_stage_sram_ctrl: RTL and testbench

Sequences multi-cycle accesses to the external 16-bit SRAM on behalf of the MEM stage. Takes the control and data outputs of the EXE/MEM pipeline register (mem_r_en, mem_w_en, ALU result as address, Val_Rm as write data). Splits each 32-bit access into two half-word SRAM cycles and returns 32-bit read data. Drives freeze to hold all pipeline registers until the access completes.

---
 rtl/mem_stage_sram_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Sequences 32-bit MEM-stage loads/stores as two half-word cycles on a 16-bit SRAM and holds the pipeline with freeze meanwhile.
// Optional one-entry read cache: define MEM_STAGE_SRAM_READ_CACHE_EN.
module mem_stage_sram_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int BASE_ADDR       = 1024,
    parameter int WAIT_CYCLES     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_r_en,
    input  logic                       mem_w_en,
    input  logic [DATA_WIDTH-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       ready,
    output logic                       freeze,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
    output logic                       sram_dq_oe,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ce_n
);
    localparam int SA = SRAM_ADDR_WIDTH;
    localparam int TW = SA - 1;
    localparam int SD = SRAM_DATA_WIDTH;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  is_load;
    logic [TW-1:0]         word;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SD-1:0]         rdata_lo;
    logic                  req;
    logic                  phase_end;
    logic [DATA_WIDTH-1:0] offset;
    logic                  unused_bits;

    assign req       = mem_r_en | mem_w_en;
    assign offset    = addr - DATA_WIDTH'(BASE_ADDR);
    assign phase_end = (cnt == CW'(WAIT_CYCLES));
    // Only the half-word index bits are meaningful; the rest wrap silently.
    assign unused_bits = ^{offset[DATA_WIDTH-1:SA+1], offset[1:0]};

    always_comb begin
        case (state)
            IDLE:    ready = ~req;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end
    assign freeze = req & ~ready;

`ifdef MEM_STAGE_SRAM_READ_CACHE_EN
    logic                  c_valid;
    logic [TW-1:0]         c_tag;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  c_hit;

    assign c_hit = mem_r_en & c_valid & (c_tag == offset[SA:2]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_load     <= 1'b0;
            word        <= '0;
            wdata_q     <= '0;
            rdata_lo    <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
`ifdef MEM_STAGE_SRAM_READ_CACHE_EN
            c_valid     <= 1'b0;
            c_tag       <= '0;
            c_data      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_load <= mem_r_en;
                        word    <= offset[SA:2];
                        wdata_q <= wdata;
                        cnt     <= '0;
`ifdef MEM_STAGE_SRAM_READ_CACHE_EN
                        if (c_hit) begin
                            state <= DONE;
                            rdata <= c_data;
                        end else
`endif
                        begin
                            // Load wins when both enables are high.
                            state       <= LO;
                            sram_addr   <= {offset[SA:2], 1'b0};
                            sram_dq_out <= wdata[SD-1:0];
                            sram_dq_oe  <= ~mem_r_en;
                            sram_we_n   <= mem_r_en;
                            sram_oe_n   <= ~mem_r_en;
                            sram_ce_n   <= 1'b0;
                        end
                    end
                end
                LO: begin
                    if (phase_end) begin
                        state       <= HI;
                        cnt         <= '0;
                        sram_addr   <= {word, 1'b1};
                        sram_dq_out <= wdata_q[DATA_WIDTH-1:SD];
                        rdata_lo    <= sram_dq_in;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HI: begin
                    if (phase_end) begin
                        state      <= DONE;
                        cnt        <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_ce_n  <= 1'b1;
                        if (is_load) begin
                            rdata <= {sram_dq_in, rdata_lo};
                        end
`ifdef MEM_STAGE_SRAM_READ_CACHE_EN
                        if (is_load) begin
                            c_valid <= 1'b1;
                            c_tag   <= word;
                            c_data  <= {sram_dq_in, rdata_lo};
                        end else if (c_valid && c_tag == word) begin
                            c_data <= wdata_q;
                        end
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: behavioural SRAM, shadow memory and a queue of expected load words.
module tb_mem_stage_sram_ctrl;
    localparam int W  = 1;
    localparam int PH = W + 1;
    localparam int FULL = 1 + 2 * PH;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;

    logic [15:0] sram_mem   [0:255];
    logic [15:0] shadow_mem [0:255];
    logic [31:0] exp_q [$];
    logic [17:0] tr_addr [0:7];
    logic [15:0] tr_dq   [0:7];
    logic        tr_we   [0:7];
    logic [17:0] wr_addr;
    int          wr_cnt = 0;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n)
    );

    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[7:0]];

    // A write commits only once we_n has been held low for a full phase at one address.
    always @(posedge clk) begin
        if (!rst && !sram_ce_n && !sram_we_n) begin
            if (wr_cnt > 0 && sram_addr == wr_addr) begin
                wr_cnt = wr_cnt + 1;
            end else begin
                wr_addr = sram_addr;
                wr_cnt  = 1;
            end
            if (wr_cnt == PH) sram_mem[sram_addr[7:0]] = sram_dq_out;
        end else begin
            wr_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int exp_stall, input int exp_we, input int exp_oe, input int exp_ce);
        int hw;
        int stall = 0, frz = 0, we_c = 0, oe_c = 0, ce_c = 0;
        bit done = 0;
        hw = (((a - 32'd1024) >> 2) * 2) & 255;
        if (r) begin
            exp_q.push_back({shadow_mem[hw + 1], shadow_mem[hw]});
        end else if (w) begin
            shadow_mem[hw]     = d[15:0];
            shadow_mem[hw + 1] = d[31:16];
        end
        mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (i < 8) begin
                tr_addr[i] = sram_addr; tr_dq[i] = sram_dq_out; tr_we[i] = sram_we_n;
            end
            we_c += !sram_we_n;
            oe_c += !sram_oe_n;
            ce_c += !sram_ce_n;
            if (ready) done = 1;
            else begin
                stall++;
                frz += freeze;
            end
        end
        check("timeout", done, 1);
        check("stall", stall, exp_stall);
        check("freeze_cycles", frz, exp_stall);
        check("freeze_done", freeze, 0);
        check("we_cycles", we_c, exp_we);
        check("oe_cycles", oe_c, exp_oe);
        check("ce_cycles", ce_c, exp_ce);
        if (r && exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
        @(posedge clk); #1;
        mem_r_en = 0; mem_w_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i]   = 16'hA000 + 16'(i);
            shadow_mem[i] = 16'hA000 + 16'(i);
        end
        rst = 1; mem_r_en = 0; mem_w_en = 0; addr = 0; wdata = 0;
        #12;
        check("rst_rdata", rdata, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq", sram_dq_out, 0);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_ready", ready, 1);
        @(posedge clk); #1 rst = 0;

        repeat (10) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
            check("idle_freeze", freeze, 0);
            check("idle_ce_n", sram_ce_n, 1);
            check("idle_we_n", sram_we_n, 1);
        end
        @(posedge clk); #1;

        access(0, 1, 32'd1028, 32'hDEADBEEF, FULL, 2 * PH, 0, 2 * PH);
        for (int i = 1; i <= 2 * PH; i++) begin
            check("st_addr", tr_addr[i], (i <= PH) ? 2 : 3);
            check("st_dq", tr_dq[i], (i <= PH) ? 32'hBEEF : 32'hDEAD);
            check("st_we_n", tr_we[i], 0);
        end
        check("sram_hw2", sram_mem[2], 16'hBEEF);
        check("sram_hw3", sram_mem[3], 16'hDEAD);

        access(1, 0, 32'd1028, 32'h0, FULL, 0, 2 * PH, 2 * PH);

        access(1, 1, 32'd1032, 32'h55556666, FULL, 0, 2 * PH, 2 * PH);
        check("both_hw4", sram_mem[4], 16'hA004);
        check("both_hw5", sram_mem[5], 16'hA005);

        // Store aborted by reset in its second HI cycle: only the low half lands.
        mem_w_en = 1; addr = 32'd1028; wdata = 32'hCAFE1234;
        shadow_mem[2] = 16'h1234;
        repeat (4) @(posedge clk);
        #2 rst = 1;
        #1;
        check("abort_we_n", sram_we_n, 1);
        check("abort_ce_n", sram_ce_n, 1);
        check("abort_dq_oe", sram_dq_oe, 0);
        mem_w_en = 0;
        @(posedge clk); #1 rst = 0;
        check("abort_ready", ready, 1);
        access(1, 0, 32'd1028, 32'h0, FULL, 0, 2 * PH, 2 * PH);
        check("abort_hw3", sram_mem[3], 16'hDEAD);

`ifdef MEM_STAGE_SRAM_READ_CACHE_EN
        access(1, 0, 32'd1028, 32'h0, 1, 0, 0, 0);
        access(0, 1, 32'd1028, 32'h12345678, FULL, 2 * PH, 0, 2 * PH);
        access(1, 0, 32'd1028, 32'h0, 1, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
